sdr_cmd_fsm: RTL and testbench

//  SDRAM command-phase state machine, directly upstream of sdr_ctrl_sig. Runs once init is done (iState==i_ready).

---
 rtl/sdr_cmd_fsm.sv | 164 ++++++++++++++++
 tb/tb_sdr_cmd_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_cmd_fsm.sv
// SDRAM command-phase FSM: arbitrates host reads/writes against auto-refresh
// and sequences ACTIVE, tRCD, READA/WRITEA, CAS latency and the data burst.
module sdr_cmd_fsm #(
   parameter int ADDR_W       = 22,
   parameter int T_RCD        = 2,
   parameter int T_RFC        = 7,
   parameter int T_RP         = 2,
   parameter int CAS_LAT      = 2,
   parameter int BURST_LEN    = 4,
   parameter int REF_INTERVAL = 1560
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              init_done,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] paddr,
   output logic              req_ready,
   output logic [3:0]        cState,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic              rd_data_valid,
   output logic              wr_data_req,
   output logic              ref_pending
);

   localparam int M0 = (T_RFC > REF_INTERVAL) ? T_RFC : REF_INTERVAL;
   localparam int M1 = (CAS_LAT > BURST_LEN) ? CAS_LAT : BURST_LEN;
   localparam int M2 = (T_RCD > T_RP + 1) ? T_RCD : T_RP + 1;
   localparam int M3 = (M0 > M1) ? M0 : M1;
   localparam int MX = (M3 > M2) ? M3 : M2;
   localparam int CW = $clog2(MX);

   typedef enum logic [3:0] {
      c_idle   = 4'd0,
      c_ACTIVE = 4'd1,
      c_tRCD   = 4'd2,
      c_READA  = 4'd3,
      c_WRITEA = 4'd4,
      c_cl     = 4'd5,
      c_rdata  = 4'd6,
      c_wdata  = 4'd7,
      c_AR     = 4'd8,
      c_tRFC   = 4'd9
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] rec_q;
   logic [CW-1:0] rec_d;
   logic [CW-1:0] tmr_q;
   logic          wr_q;
   logic          accept;
   logic          ar_clr;
   logic          tmr_hit;

   assign req_ready = presetn & (state_q == c_idle) & init_done
                    & ~ref_pending & (rec_q == '0);
   assign accept    = req_valid & req_ready;
   assign tmr_hit   = init_done & (tmr_q == CW'(REF_INTERVAL - 1));

   assign cState        = state_q;
   assign rd_data_valid = (state_q == c_rdata);
   assign wr_data_req   = (state_q == c_WRITEA) | (state_q == c_wdata);

   // Each hold state loads cnt with (cycles to stay - 1) on entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rec_d   = (rec_q != '0) ? rec_q - CW'(1) : '0;
      ar_clr  = 1'b0;
      unique case (state_q)
         c_idle: begin
            if (init_done & ref_pending & (rec_q == '0)) begin
               state_d = c_AR;
               ar_clr  = 1'b1;
            end else if (accept) begin
               state_d = c_ACTIVE;
            end
         end
         c_ACTIVE: begin
            state_d = c_tRCD;
            cnt_d   = CW'(T_RCD - 2);
         end
         c_tRCD: begin
            if (cnt_q == '0) state_d = wr_q ? c_WRITEA : c_READA;
            else             cnt_d   = cnt_q - CW'(1);
         end
         c_READA: begin
            state_d = c_cl;
            cnt_d   = CW'(CAS_LAT - 1);
         end
         c_cl: begin
            if (cnt_q == '0) begin
               state_d = c_rdata;
               cnt_d   = CW'(BURST_LEN - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         c_rdata: begin
            if (cnt_q == '0) begin
               state_d = c_idle;
               rec_d   = CW'(T_RP);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         c_WRITEA: begin
            if (BURST_LEN == 1) begin
               state_d = c_idle;
               rec_d   = CW'(T_RP);
            end else begin
               state_d = c_wdata;
               cnt_d   = CW'(BURST_LEN - 2);
            end
         end
         c_wdata: begin
            if (cnt_q == '0) begin
               state_d = c_idle;
               rec_d   = CW'(T_RP);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         c_AR: begin
            state_d = c_tRFC;
            cnt_d   = CW'(T_RFC - 2);
         end
         c_tRFC: begin
            if (cnt_q == '0) state_d = c_idle;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = c_idle;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= c_idle;
         cnt_q       <= '0;
         rec_q       <= '0;
         tmr_q       <= '0;
         wr_q        <= 1'b0;
         cmd_addr    <= '0;
         ref_pending <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rec_q   <= rec_d;
         if (accept) begin
            cmd_addr <= paddr;
            wr_q     <= req_write;
         end
         if (!init_done || tmr_hit) tmr_q <= '0;
         else                       tmr_q <= tmr_q + CW'(1);
         // A new expiry beats the clear from a same-cycle refresh issue.
         if (tmr_hit)     ref_pending <= 1'b1;
         else if (ar_clr) ref_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sdr_cmd_fsm.sv
// Bench for sdr_cmd_fsm: expected per-cycle outputs are queued when a
// request is driven and compared one entry per clock by a monitor.
module tb_sdr_cmd_fsm;

   localparam int AW   = 22;
   localparam int RI   = 16;
   localparam int TRCD = 2;
   localparam int TRFC = 7;
   localparam int TRP  = 2;
   localparam int CL   = 2;
   localparam int BL   = 4;

   logic          clk = 1'b0;
   logic          presetn = 1'b0;
   logic          init_done = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] paddr = '0;
   logic          req_ready;
   logic [3:0]    cState;
   logic [AW-1:0] cmd_addr;
   logic          rd_data_valid;
   logic          wr_data_req;
   logic          ref_pending;

   sdr_cmd_fsm #(
      .ADDR_W(AW), .T_RCD(TRCD), .T_RFC(TRFC), .T_RP(TRP),
      .CAS_LAT(CL), .BURST_LEN(BL), .REF_INTERVAL(RI)
   ) dut (
      .pclk(clk), .presetn(presetn), .init_done(init_done),
      .req_valid(req_valid), .req_write(req_write), .paddr(paddr),
      .req_ready(req_ready), .cState(cState), .cmd_addr(cmd_addr),
      .rd_data_valid(rd_data_valid), .wr_data_req(wr_data_req),
      .ref_pending(ref_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    st;
      logic          rdy;
      logic          rp;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t          q[$];
   exp_t          mon_e;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [AW-1:0] exp_addr = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void push(input logic [3:0] st, input logic rdy,
                                input logic rp);
      exp_t e;
      e.st   = st;
      e.rdy  = rdy;
      e.rp   = rp;
      e.addr = exp_addr;
      q.push_back(e);
   endfunction

   function automatic void push_read(input logic [AW-1:0] a,
                                     input logic last_rdy);
      exp_addr = a;
      push(4'd1, 1'b0, 1'b0);
      repeat (TRCD - 1) push(4'd2, 1'b0, 1'b0);
      push(4'd3, 1'b0, 1'b0);
      repeat (CL) push(4'd5, 1'b0, 1'b0);
      repeat (BL) push(4'd6, 1'b0, 1'b0);
      repeat (TRP) push(4'd0, 1'b0, 1'b0);
      push(4'd0, last_rdy, 1'b0);
   endfunction

   function automatic void push_write(input logic [AW-1:0] a,
                                      input logic last_rdy);
      exp_addr = a;
      push(4'd1, 1'b0, 1'b0);
      repeat (TRCD - 1) push(4'd2, 1'b0, 1'b0);
      push(4'd4, 1'b0, 1'b0);
      repeat (BL - 1) push(4'd7, 1'b0, 1'b0);
      repeat (TRP) push(4'd0, 1'b0, 1'b0);
      push(4'd0, last_rdy, 1'b0);
   endfunction

   // Refresh from a freshly started timer, then back to idle.
   function automatic void push_refresh();
      repeat (RI - 1) push(4'd0, 1'b1, 1'b0);
      push(4'd0, 1'b0, 1'b1);
      push(4'd8, 1'b0, 1'b0);
      repeat (TRFC - 1) push(4'd9, 1'b0, 1'b0);
      push(4'd0, 1'b1, 1'b0);
   endfunction

   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         chk("cState", 32'(cState), 32'(mon_e.st));
         chk("rd_data_valid", 32'(rd_data_valid), 32'(mon_e.st == 4'd6));
         chk("wr_data_req", 32'(wr_data_req),
             32'((mon_e.st == 4'd4) || (mon_e.st == 4'd7)));
         chk("req_ready", 32'(req_ready), 32'(mon_e.rdy));
         chk("ref_pending", 32'(ref_pending), 32'(mon_e.rp));
         chk("cmd_addr", 32'(cmd_addr), 32'(mon_e.addr));
      end
   end

   task automatic drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic idle2();
      init_done = 1'b0;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, got timeout want done");
      $fatal(1, "watchdog");
   end

   initial begin
      init_done = 1'b1;
      req_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_cState", 32'(cState), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
      chk("rst_ref_pending", 32'(ref_pending), 32'd0);
      chk("rst_rdv", 32'(rd_data_valid), 32'd0);
      chk("rst_wdr", 32'(wr_data_req), 32'd0);
      idle2();
      presetn = 1'b1;
      @(negedge clk);

      // single read
      init_done = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      paddr     = 22'h12345;
      push_read(22'h12345, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      drain();
      idle2();

      // single write
      init_done = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      paddr     = 22'h2A5A5;
      push_write(22'h2A5A5, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
      drain();
      idle2();

      // back-to-back reads, second held valid through recovery
      init_done = 1'b1;
      req_valid = 1'b1;
      paddr     = 22'h00ABC;
      push_read(22'h00ABC, 1'b1);
      push_read(22'h3F00F, 1'b0);
      @(negedge clk);
      paddr = 22'h3F00F;
      repeat (12) @(negedge clk);
      req_valid = 1'b0;
      init_done = 1'b0;
      drain();
      idle2();

      // refresh collides with a pending request
      init_done = 1'b1;
      repeat (RI - 1) push(4'd0, 1'b1, 1'b0);
      push(4'd0, 1'b0, 1'b1);
      repeat (RI) @(negedge clk);
      req_valid = 1'b1;
      paddr     = 22'h15555;
      push(4'd8, 1'b0, 1'b0);
      repeat (TRFC - 1) push(4'd9, 1'b0, 1'b0);
      push(4'd0, 1'b1, 1'b0);
      push_read(22'h15555, 1'b0);
      repeat (TRFC + 2) @(negedge clk);
      req_valid = 1'b0;
      init_done = 1'b0;
      drain();
      idle2();

      // reset in the middle of a read burst
      init_done = 1'b1;
      req_valid = 1'b1;
      paddr     = 22'h3C3C3;
      exp_addr  = 22'h3C3C3;
      push(4'd1, 1'b0, 1'b0);
      repeat (TRCD - 1) push(4'd2, 1'b0, 1'b0);
      push(4'd3, 1'b0, 1'b0);
      repeat (CL) push(4'd5, 1'b0, 1'b0);
      push(4'd6, 1'b0, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      init_done = 1'b0;
      repeat (TRCD + CL + 1) @(negedge clk);
      chk("t6_queue_empty", 32'(q.size()), 32'd0);
      presetn = 1'b0;
      #1;
      chk("t6_cState", 32'(cState), 32'd0);
      chk("t6_rdv", 32'(rd_data_valid), 32'd0);
      chk("t6_req_ready", 32'(req_ready), 32'd0);
      chk("t6_cmd_addr", 32'(cmd_addr), 32'd0);
      exp_addr  = '0;
      req_valid = 1'b1;
      @(negedge clk);
      presetn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t6_noinit_cState", 32'(cState), 32'd0);
         chk("t6_noinit_ready", 32'(req_ready), 32'd0);
         chk("t6_noinit_refp", 32'(ref_pending), 32'd0);
      end
      req_valid = 1'b0;

      // refresh after reset: timer must start from zero
      init_done = 1'b1;
      push_refresh();
      drain();
      idle2();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
